// File: rtl/led_array_scan_ctrl.sv
// SPI-loaded, double-buffered LED row scanner with tear-free swaps; outputs registered (1-cycle latency), no backpressure.
// Optional PWM brightness control is built in when LED_ARRAY_PWM_EN is defined.
module led_array_scan_ctrl #(
  parameter int COLS    = 24,
  parameter int ROWS    = 8,
  parameter int DWELL   = 1000,
  parameter int BLANK   = 8,
  parameter int FRAME_W = 32,
  localparam int ROW_AW = $clog2(ROWS)
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_SPI_CLK,
  input  logic              i_SPI_ENA_n,
  input  logic              i_SPI_DATA,
  input  logic              i_ENA_p,
  output logic [COLS-1:0]   o_LED,
  output logic              o_TOGGLE_SYNC,
  output logic              o_HEAD_FLAG,
  output logic [ROW_AW-1:0] o_ROW,
  output logic              o_FRAME_ERR
);

  localparam int DW_W  = $clog2(DWELL);
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [DW_W-1:0]   BLANK_V    = DW_W'(BLANK);
  localparam logic [ROW_AW-1:0] ROW_LAST   = ROW_AW'(ROWS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
  localparam logic [7:0]        ROWS_V     = 8'(ROWS);

  logic [2:0]          r_sclk_sync;
  logic [2:0]          r_ena_sync;
  logic [1:0]          r_dat_sync;
  logic [FRAME_W-1:0]  r_sr;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_in_frame;
  logic                r_frame_err;
  logic                r_wr_vld;
  logic [ROW_AW-1:0]   r_wr_row;
  logic [COLS-1:0]     r_wr_dat;

  logic [COLS-1:0]     r_buf [2][ROWS];
  logic                r_active;
  logic                r_swap_pend;
  logic [ROW_AW-1:0]   r_row;
  logic [DW_W-1:0]     r_dwell;
  logic                r_tog;
  logic [COLS-1:0]     r_led;
  logic [ROW_AW-1:0]   r_row_out;
  logic                r_head;

  logic                w_sclk_rise;
  logic                w_ena_fall;
  logic                w_ena_rise;
  logic [7:0]          w_cmd;
  logic                w_accept;
  logic                w_row_ok;
  logic                w_swap_req;
  logic                w_swap_now;
  logic                w_is_bright;
  logic                w_pwm_off;

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_ena_fall  = ~r_ena_sync[1] & r_ena_sync[2];
  assign w_ena_rise  = r_ena_sync[1] & ~r_ena_sync[2];
  assign w_cmd       = r_sr[FRAME_W-1 -: 8];
  assign w_accept    = w_ena_rise & r_in_frame & (r_bit_cnt == CNT_FULL);
  assign w_row_ok    = {1'b0, w_cmd[6:0]} < ROWS_V;
  assign w_swap_req  = w_accept & w_cmd[7];
  assign w_swap_now  = r_swap_pend &
                       (~i_ENA_p | ((r_dwell == DWELL_LAST) & (r_row == ROW_LAST)));

`ifdef LED_ARRAY_PWM_EN
  logic [7:0] r_pwm;
  logic [7:0] r_bright;

  assign w_is_bright = (w_cmd == 8'h7F);
  assign w_pwm_off   = (r_pwm >= r_bright);

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_pwm    <= '0;
      r_bright <= 8'hFF;
    end else begin
      r_pwm <= r_pwm + 8'd1;
      if (w_accept && w_is_bright)
        r_bright <= r_sr[7:0];
    end
  end
`else
  assign w_is_bright = 1'b0;
  assign w_pwm_off   = 1'b0;
`endif

  // SPI capture: a frame is tracked only from a falling ENA_n seen after reset,
  // so a frame cut by reset is dropped silently.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_sclk_sync <= '0;
      r_ena_sync  <= '0;
      r_dat_sync  <= '0;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_in_frame  <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_vld    <= 1'b0;
      r_wr_row    <= '0;
      r_wr_dat    <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i_SPI_CLK};
      r_ena_sync  <= {r_ena_sync[1:0], i_SPI_ENA_n};
      r_dat_sync  <= {r_dat_sync[0], i_SPI_DATA};
      r_frame_err <= w_ena_rise & r_in_frame & (r_bit_cnt != CNT_FULL);
      r_wr_vld    <= w_accept & w_row_ok & ~w_is_bright;
      r_wr_row    <= w_cmd[ROW_AW-1:0];
      r_wr_dat    <= r_sr[COLS-1:0];
      if (w_ena_fall) begin
        r_in_frame <= 1'b1;
        r_bit_cnt  <= '0;
      end else if (w_ena_rise) begin
        r_in_frame <= 1'b0;
      end else if (r_in_frame && w_sclk_rise) begin
        r_sr <= {r_sr[FRAME_W-2:0], r_dat_sync[1]};
        if (r_bit_cnt != CNT_SAT)
          r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Writes target the back buffer using the pre-swap select, so a write and
  // swap landing together still fill the old back buffer.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          r_buf[b][r] <= '0;
      r_active    <= 1'b0;
      r_swap_pend <= 1'b0;
      r_row       <= '0;
      r_dwell     <= '0;
      r_tog       <= 1'b0;
      r_led       <= '0;
      r_row_out   <= '0;
      r_head      <= 1'b0;
    end else begin
      if (r_wr_vld)
        r_buf[~r_active][r_wr_row] <= r_wr_dat;
      if (w_swap_now) begin
        r_active    <= ~r_active;
        r_swap_pend <= 1'b0;
      end else if (w_swap_req) begin
        r_swap_pend <= 1'b1;
      end
      if (i_ENA_p) begin
        r_led     <= ((r_dwell < BLANK_V) || w_pwm_off) ? '0 : r_buf[r_active][r_row];
        r_row_out <= r_row;
        r_head    <= (r_row == '0);
        if (r_dwell == DWELL_LAST) begin
          r_dwell <= '0;
          r_row   <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
          r_tog   <= ~r_tog;
        end else begin
          r_dwell <= r_dwell + 1'b1;
        end
      end else begin
        r_row     <= '0;
        r_dwell   <= '0;
        r_led     <= '0;
        r_row_out <= '0;
        r_head    <= 1'b1;
      end
    end
  end

  assign o_LED         = r_led;
  assign o_TOGGLE_SYNC = r_tog;
  assign o_HEAD_FLAG   = r_head;
  assign o_ROW         = r_row_out;
  assign o_FRAME_ERR   = r_frame_err;

endmodule

// File: doc/led_array_scan_ctrl.md
Name: led_array_scan_ctrl

Overview:
- Parametrised successor to the fixed 32-bit LED array main controller.
- Receives SPI frames through a synchronised serial port, sampled on i_CLK. Each frame carries an 8-bit command and row data.
- Frames are written into a double-buffered ROWS x COLS pattern memory. The active buffer is scanned row by row, with the TOGGLE_SYNC/HEAD_FLAG pair driving the sub (sink) board.
- Buffer swaps are tear-free: they happen only at scan-frame boundaries.

Parameters:
- COLS, 24, LED columns per row and width of the SPI data field (1..24).
- ROWS, 8, scanned rows (2..128); ROW_AW = clog2(ROWS).
- DWELL, 1000, i_CLK cycles each row is lit, including blanking (>= BLANK+2).
- BLANK, 8, cycles o_LED is forced to 0 at the start of each row.
- FRAME_W, 32, SPI frame length in bits (8-bit command + 24-bit data).

Ports:
- i_CLK  in  1  system clock; must be >= 4x SPI clock.
- i_RESET  in  1  synchronous, active-high reset.
- i_SPI_CLK  in  1  SPI clock, idle high; data sampled on rising edge.
- i_SPI_ENA_n  in  1  SPI frame enable, active low.
- i_SPI_DATA  in  1  SPI data, MSB first.
- i_ENA_p  in  1  scan enable.
- o_LED  out  COLS  column drive for the current row.
- o_TOGGLE_SYNC  out  1  toggles at every row advance.
- o_HEAD_FLAG  out  1  high while row 0 is displayed.
- o_ROW  out  ROW_AW  current row index.
- o_FRAME_ERR  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset values:
  - All outputs 0. Row counter 0, dwell counter 0.
  - Both buffers cleared. Active buffer = 0. Swap-pending cleared. SPI shift register and bit counter cleared.
- SPI input path:
  - i_SPI_CLK, i_SPI_ENA_n and i_SPI_DATA each pass through a 2-FF synchroniser.
  - A rising SPI clock edge is detected on the synchronised signal.
  - While synchronised ENA_n is low, each detected rising edge shifts DATA into the LSB of the shift register. The bit counter saturates at FRAME_W+1.
  - On the synchronised ENA_n falling edge, the bit counter is cleared.
- Frame completion (synchronised ENA_n rising edge):
  - If count == FRAME_W, the frame is accepted. Otherwise o_FRAME_ERR pulses for 1 cycle and nothing is written.
  - Accepted frame fields: cmd = sr[31:24], data = sr[COLS-1:0].
  - If cmd[6:0] < ROWS, the back buffer at row cmd[ROW_AW-1:0] is written with data on the next cycle. Otherwise the write is skipped without error.
  - If cmd[7] = 1, swap-pending is set. The swap bit is honoured even when the row address is out of range.
- Swap timing:
  - With i_ENA_p = 1, the swap is applied on the cycle the row counter wraps ROWS-1 -> 0. Pending is then cleared.
  - With i_ENA_p = 0, the swap is applied on the cycle after pending is set.
  - A second swap request while one is pending is absorbed (no double swap).
- Scanner, i_ENA_p = 1:
  - The dwell counter counts 0..DWELL-1.
  - At DWELL-1: the row advances (wrapping at ROWS-1), o_TOGGLE_SYNC inverts, and the dwell counter returns to 0.
  - o_LED = 0 while dwell < BLANK; otherwise o_LED = active_buf[row]. All outputs are registered (1-cycle latency from counter state).
  - o_HEAD_FLAG = (row == 0), registered together with o_ROW.
- Scanner, i_ENA_p = 0:
  - On the next cycle: row = 0, dwell = 0, o_LED = 0, o_HEAD_FLAG = 1.
  - o_TOGGLE_SYNC holds its value.
  - When i_ENA_p re-asserts, scanning starts at row 0 from dwell 0.
- Simultaneous events:
  - A frame write to the back buffer coincident with a swap: the write completes into the old back buffer first; the swap follows the same cycle's rules.
  - Reset mid-frame discards the partial frame with no error pulse.
  - Reset mid-scan returns all state to reset values.

Optional Feature:
- Macro: LED_ARRAY_PWM_EN.
- When defined:
  - Command 0x7F with cmd[7] = 0 is a brightness write: data[7:0] loads the BRIGHT register (reset 0xFF) and no row write occurs.
  - An 8-bit free-running PWM counter (reset 0) runs on i_CLK.
  - o_LED is masked to 0 whenever pwm >= BRIGHT, in addition to blanking. BRIGHT = 0 gives fully dark output; BRIGHT = 0xFF gives 255/256 duty.
- When undefined: 0x7F is treated as an ordinary out-of-range row address, and no PWM logic is present.

Test Plan:
- Reset, then SPI frame {8'h80, 24'h000100}, then i_ENA_p = 1 -> after the first wrap, row 0 shows o_LED = 0x000100 after the BLANK cycles, with o_HEAD_FLAG = 1; rows 1..7 show 0.
- Frames writing rows 0..7 with 1<<row, then a swap, with ROWS = 8 and DWELL = 1000 -> o_ROW steps every 1000 cycles, o_TOGGLE_SYNC toggles 8 times per scan, o_LED = 1<<o_ROW.
- Swap requested mid-scan at row 3 -> the active buffer does not change until the cycle o_ROW wraps 7 -> 0.
- 31-bit frame, then a 33-bit frame -> o_FRAME_ERR pulses once after each; buffer contents are unchanged.
- i_ENA_p dropped at row 5 -> next cycle o_LED = 0, o_ROW = 0, o_HEAD_FLAG = 1, toggle frozen; on re-enable, the first advance occurs after 1000 cycles.
- With LED_ARRAY_PWM_EN defined, a brightness write of 0x40 -> o_LED is non-zero for exactly 64 of every 256 cycles outside blanking.
